// File: rtl/button_pkg.sv
// Shared types and helpers for the button conditioner.
//   rpt_state_e : per-channel auto-repeat state
//   btn_evt_t   : per-channel registered output bundle
//   max_u       : larger of two unsigned values
//   cnt_width   : bits needed to hold 0..max_cnt (never less than 1)
package button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic action;
    } btn_evt_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_cnt);
        return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between pin-facing logic and the conditioner.
//   btn_raw     : raw asynchronous button pins
//   btn_level   : debounced pressed level, 1 = pressed
//   btn_press   : one-cycle pulse on accepted press
//   btn_release : one-cycle pulse on accepted release
//   btn_action  : one-cycle pulse on press or auto-repeat
// master drives the pins and consumes events; slave is the conditioner.
interface button_conditioner_if #(
    parameter int unsigned N_BTN = 3
) ();

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_action;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_action
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_action
    );

endinterface

// File: rtl/button_channel.sv
// One button channel: polarity fix, synchroniser, debounce, edge pulses
// and auto-repeat FSM.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   btn_raw_i : raw asynchronous pin
//   evt_o     : registered {level, press, rel, action}
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD   = 3125000,
    parameter bit          ACTIVE_LOW      = 1'b0,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     btn_raw_i,
    output btn_evt_t evt_o
);

    localparam int unsigned DEB_W = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int unsigned RPT_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD) - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced_c;

    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             action_q, action_d;

    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_tc_c;
    logic             rpt_pulse_c;

    assign synced_c = sync_q[SYNC_STAGES-1];
    assign rpt_tc_c = (rpt_cnt_q == '0);

    // Debounce: count consecutive edges where synced disagrees with level;
    // toggle on the last one and raise the matching edge pulse in the same edge.
    always_comb begin
        deb_cnt_d = '0;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (synced_c != level_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d   = ~level_q;
                press_d   = ~level_q;
                release_d = level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Repeat FSM next state; release always wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (press_d && REPEAT_EN) state_d = DELAY;
            end
            DELAY: begin
                if (release_d)     state_d = IDLE;
                else if (rpt_tc_c) state_d = REPEAT;
            end
            REPEAT: begin
                if (release_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Repeat FSM outputs: counter reload/decrement and repeat pulse.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_pulse_c = 1'b0;
        case (state_q)
            IDLE: begin
                rpt_cnt_d = (state_d == DELAY) ? RPT_W'(REPEAT_DELAY - 1) : '0;
            end
            DELAY, REPEAT: begin
                if (release_d) begin
                    rpt_cnt_d = '0;
                end else if (rpt_tc_c) begin
                    rpt_pulse_c = 1'b1;
                    rpt_cnt_d   = RPT_W'(REPEAT_PERIOD - 1);
                end else begin
                    rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
                end
            end
            default: rpt_cnt_d = '0;
        endcase
        action_d = press_d | rpt_pulse_c;
    end

    // Synchroniser, FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            action_q  <= 1'b0;
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_raw_i ^ ACTIVE_LOW};
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            action_q  <= action_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign evt_o.level  = level_q;
    assign evt_o.press  = press_q;
    assign evt_o.rel    = release_q;
    assign evt_o.action = action_q;

endmodule

// File: rtl/button_conditioner.sv
// N_BTN independent button channels: synchronise, debounce, emit
// press/release pulses and auto-repeating action pulses.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   btn_if : slave side of the button bundle (raw in, events out)
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned      N_BTN           = 3,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 250000,
    parameter int unsigned      REPEAT_DELAY    = 12500000,
    parameter int unsigned      REPEAT_PERIOD   = 3125000,
    parameter logic [N_BTN-1:0] ACTIVE_LOW      = '0,
    parameter logic [N_BTN-1:0] REPEAT_EN       = '1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_conditioner_if.slave  btn_if
);

    btn_evt_t         evt_w [N_BTN];
    logic [N_BTN-1:0] level_w;
    logic [N_BTN-1:0] press_w;
    logic [N_BTN-1:0] release_w;
    logic [N_BTN-1:0] action_w;

    for (genvar g = 0; g < int'(N_BTN); g++) begin : g_ch
        button_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .ACTIVE_LOW      (ACTIVE_LOW[g]),
            .REPEAT_EN       (REPEAT_EN[g])
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_raw_i (btn_if.btn_raw[g]),
            .evt_o     (evt_w[g])
        );
    end

    // Gather per-channel bundles into the bus vectors.
    always_comb begin
        level_w   = '0;
        press_w   = '0;
        release_w = '0;
        action_w  = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            level_w[i]   = evt_w[i].level;
            press_w[i]   = evt_w[i].press;
            release_w[i] = evt_w[i].rel;
            action_w[i]  = evt_w[i].action;
        end
    end

    assign btn_if.btn_level   = level_w;
    assign btn_if.btn_press   = press_w;
    assign btn_if.btn_release = release_w;
    assign btn_if.btn_action  = action_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing parameters.
// Channel 0 is active-low, channel 2 has auto-repeat disabled.
module tb_button_conditioner;

    localparam logic [2:0] AL_MASK = 3'b001;

    typedef struct packed {
        logic [2:0] pressed;
        logic [2:0] level;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] act;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs [$];

    button_conditioner_if #(.N_BTN(3)) btn_if ();

    button_conditioner #(
        .N_BTN           (3),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (3),
        .ACTIVE_LOW      (AL_MASK),
        .REPEAT_EN       (3'b011)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_if (btn_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] outs();
        return {btn_if.btn_level, btn_if.btn_press, btn_if.btn_release, btn_if.btn_action};
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got lvl/prs/rel/act=%b_%b_%b_%b expected %b_%b_%b_%b",
                     name, got[11:9], got[8:6], got[5:3], got[2:0],
                     exp[11:9], exp[8:6], exp[5:3], exp[2:0]);
        end
    endtask

    // Apply a logical "pressed" pattern before the next rising edge, then sample after it.
    task automatic step(input logic [2:0] pressed);
        @(negedge clk);
        btn_if.btn_raw = pressed ^ AL_MASK;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [2:0] p, input logic [2:0] l, input logic [2:0] pr,
                                input logic [2:0] r, input logic [2:0] a);
        vec_t v;
        v.pressed = p;
        v.level   = l;
        v.press   = pr;
        v.rel     = r;
        v.act     = a;
        vecs.push_back(v);
    endfunction

    function automatic logic [2:0] b(input bit cond, input logic [2:0] mask);
        return cond ? mask : 3'b000;
    endfunction

    initial begin
        checks = 0;
        errors = 0;

        // Clean ch0 press held 20 clocks (raw pin driven low). Release is accepted at
        // cycle 26, which is also the next repeat terminal, so no action there.
        for (int c = 1; c <= 30; c++)
            add(b(c <= 20, 3'b001), b(c >= 6 && c <= 25, 3'b001), b(c == 6, 3'b001),
                b(c == 26, 3'b001),
                b(c == 6 || c == 14 || c == 17 || c == 20 || c == 23, 3'b001));
        // 3-clock glitch on ch1: nothing moves.
        for (int c = 1; c <= 10; c++)
            add(b(c <= 3, 3'b010), 3'b000, 3'b000, 3'b000, 3'b000);
        // ch2 held 30 clocks with repeat disabled: single action, release 6 edges after.
        for (int c = 1; c <= 40; c++)
            add(b(c <= 30, 3'b100), b(c >= 6 && c <= 35, 3'b100), b(c == 6, 3'b100),
                b(c == 36, 3'b100), b(c == 6, 3'b100));
        // ch1 release accepted on the first repeat terminal edge: no repeat action.
        for (int c = 1; c <= 20; c++)
            add(b(c <= 8, 3'b010), b(c >= 6 && c <= 13, 3'b010), b(c == 6, 3'b010),
                b(c == 14, 3'b010), b(c == 6, 3'b010));
        // ch1 and ch2 together: same-cycle press/release, only ch1 repeats.
        for (int c = 1; c <= 20; c++)
            add(b(c <= 10, 3'b110), b(c >= 6 && c <= 15, 3'b110), b(c == 6, 3'b110),
                b(c == 16, 3'b110), b(c == 6, 3'b110) | b(c == 14, 3'b010));

        // Reset state.
        rst_n = 1'b0;
        btn_if.btn_raw = AL_MASK;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs(), 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].pressed);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].level, vecs[i].press, vecs[i].rel, vecs[i].act});
        end

        // Async reset while ch1 is in REPEAT, button kept held through reset.
        for (int c = 1; c <= 20; c++) step(3'b010);
        check("pre_reset_level", {btn_if.btn_level, 9'h000}, {3'b010, 9'h000});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), 12'h000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_reset_c%0d", c), outs(),
                  {b(c >= 6, 3'b010), b(c == 6, 3'b010), 3'b000,
                   b(c == 6 || c == 14, 3'b010)});
        end

        for (int c = 1; c <= 8; c++) step(3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
